wbpipe_ram: RTL
===============

// Module: wbpipe_ram
// PURPOSE
//  Pipelined Wishbone responder (slave): on-chip RAM that accepts one request per clock
//  and returns ack/err plus read data after a fixed latency.
//  It is the far end of the CPU's pipelined memory unit: it sits on the local or global
//  bus and gives that unit a single-cycle-throughput target.
//  Also serves as a bench target for err, stall and abort handling.
// PARAMETERS
//  AW      32  bus address width (word addresses)
//  LGMEMSZ 10  log2 of RAM depth in 32-bit words; addresses >= 2**LGMEMSZ are errors
//  LAT     2   accept-to-ack latency in clocks, legal range 1..8
//  MAXOUT  4   max outstanding requests (accepted, not yet acked/erred), range 1..15
// PORTS
//  i_clk       in   1    clock, all logic on rising edge
//  i_rst       in   1    synchronous active-high reset
//  i_wb_cyc    in   1    bus cycle active
//  i_wb_stb    in   1    request strobe
//  i_wb_we     in   1    1 = write, 0 = read
//  i_wb_addr   in   AW   word address
//  i_wb_data   in   32   write data
//  o_wb_ack    out  1    request completed OK, one pulse per accepted good request
//  o_wb_stall  out  1    request not accepted this cycle
//  o_wb_err    out  1    bus error, one pulse, for the offending request
//  o_wb_data   out  32   read data, valid when o_wb_ack is high for a read
// BEHAVIOUR
//  - Reset (i_rst=1 at an edge) clears ack, err, data, the pipe valid bits and the
//    outstanding count to 0. RAM contents are NOT reset.
//  - Accept = i_wb_cyc && i_wb_stb && !o_wb_stall.
//  - o_wb_stall is combinational: (count == MAXOUT) && !(completion this cycle).
//  - count: 4-bit. +1 on accept, -1 on ack or err; both together leaves it unchanged.
//    count never exceeds MAXOUT and never underflows.
//  - Pipe: a LAT-stage shift register, each stage holds {valid, we, bad}.
//    - Stage 0 loads on the accept edge; the last stage drives ack/err.
//    - A request accepted at edge k gives a one-cycle ack/err pulse registered at
//      edge k+LAT.
//    - Back-to-back accepts give back-to-back acks.
//  - Error check: bad = (i_wb_addr >> LGMEMSZ) != 0.
//    - A bad request gives o_wb_err instead of o_wb_ack.
//    - A bad write leaves the RAM unmodified.
//  - Writes: RAM[addr] is written on the accept edge. Ack follows LAT clocks later.
//  - Reads: RAM read on the accept edge, data carried down the pipe. o_wb_data is
//    registered together with ack.
//  - Ordering: a read accepted after a write to the same address returns the new data,
//    including back-to-back.
//  - On a bad read, o_wb_data is don't-care.
//  - After o_wb_err: all other in-flight pipe entries are invalidated on the same edge
//    and count goes to 0. No further ack/err until new accepts.
//  - Abort: i_wb_cyc low at an edge clears all pipe valid bits and count.
//    - Acks/errs owed to that cycle are never produced.
//    - o_wb_ack/o_wb_err are forced 0 while i_wb_cyc is low.
//    - Writes already accepted stay committed.
//  - i_wb_stb while i_wb_cyc is low is ignored.
//  - A reset in mid-transfer drops everything in flight, same as an abort.
//  - Ack and err are never high in the same cycle.
// TESTING
//  1. LAT=2: read addr 5 at edge 10 after a prior write of 0xDEADBEEF to 5.
//     -> ack=1 with data=0xDEADBEEF after edge 12 only.
//  2. Stream 8 back-to-back writes to 0..7, then 8 reads, with MAXOUT>=LAT.
//     -> stall never asserted; 16 consecutive acks; reads return the written values in order.
//  3. MAXOUT=1, LAT=3: stb held high for 3 requests.
//     -> stall high between accepts; exactly one outstanding; 3 acks, each 3 clocks
//        after its accept.
//  4. LGMEMSZ=10: write addr 0x400 between reads of 1 and 2.
//     -> ack(1), then err, then no ack for 2; count=0; RAM[0] unchanged.
//  5. Issue 3 reads, drop cyc 1 clock after the last accept.
//     -> no ack/err appears; the next cycle starts with count=0 and correct latency.
//  6. Assert i_rst mid-burst. -> ack, err, stall, data = 0 next cycle;
//     previously written RAM words still readable.

Source files
------------

// File: rtl/wbpipe_ram.sv
// wbpipe_ram: pipelined Wishbone RAM responder, one request per clock, fixed LAT-clock ack.
// Out-of-range addresses answer with err; an err or a dropped cyc flushes everything in flight.
module wbpipe_ram #(
  parameter int unsigned AW      = 32,
  parameter int unsigned LGMEMSZ = 10,
  parameter int unsigned LAT     = 2,
  parameter int unsigned MAXOUT  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [31:0]   i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic          o_wb_err,
  output logic [31:0]   o_wb_data
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << LGMEMSZ;

  logic [DW-1:0]      mem [DEPTH];
  logic [DW-1:0]      pdata_q [LAT];

  logic [LAT-1:0]     valid_q, valid_d;
  logic [LAT-1:0]     we_q, we_d;
  logic [LAT-1:0]     bad_q, bad_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [DW-1:0]      data_q, data_d;

  logic               accept_c;
  logic               bad_c;
  logic               done_c;
  logic               fail_c;
  logic [LGMEMSZ-1:0] idx_c;

  assign idx_c  = i_wb_addr[LGMEMSZ-1:0];
  assign bad_c  = (i_wb_addr >> LGMEMSZ) != '0;
  // done_c: the last stage retires at the coming edge, freeing a slot this cycle
  assign done_c = i_wb_cyc && valid_q[LAT-1];
  assign fail_c = done_c && bad_q[LAT-1];

  assign o_wb_stall = (count_q == CW'(MAXOUT)) && !done_c;
  assign accept_c   = i_wb_cyc && i_wb_stb && !o_wb_stall;

  // RAM array and read-data pipe; contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (accept_c && !i_rst && i_wb_we && !bad_c) begin
      mem[idx_c] <= i_wb_data;
    end
    if (accept_c && !i_wb_we) begin
      pdata_q[0] <= mem[idx_c];
    end
    for (int i = 1; i < LAT; i++) begin
      pdata_q[i] <= pdata_q[i-1];
    end
  end

  always_comb begin
    valid_d    = '0;
    we_d       = '0;
    bad_d      = '0;
    valid_d[0] = accept_c;
    we_d[0]    = i_wb_we;
    bad_d[0]   = bad_c;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1] && !fail_c;
      we_d[i]    = we_q[i-1];
      bad_d[i]   = bad_q[i-1];
    end

    count_d = count_q + CW'(accept_c) - CW'(done_c);
    if (fail_c) begin
      count_d = CW'(accept_c);
    end

    ack_d  = done_c && !bad_q[LAT-1];
    err_d  = fail_c;
    data_d = data_q;
    if (ack_d && !we_q[LAT-1]) begin
      data_d = pdata_q[LAT-1];
    end

    // abort: whatever the master dropped is never answered
    if (!i_wb_cyc) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      we_q    <= '0;
      bad_q   <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign o_wb_ack  = ack_q && i_wb_cyc;
  assign o_wb_err  = err_q && i_wb_cyc;
  assign o_wb_data = data_q;

endmodule
